// File: rtl/cmos_frame_buf_ctrl.sv
// cmos_frame_buf_ctrl: rotates a small pool of frame buffers between a CMOS
// frame writer and a display reader so the writer never lands on the buffer
// the reader has locked.
// Optional feature: define FRAME_DROP_CNT_EN to build the saturating 16-bit
// dropped/aborted frame counter; otherwise frame_drop_cnt is tied to zero.
module cmos_frame_buf_ctrl #(
    parameter int unsigned BUF_NUM = 3,
    localparam int unsigned IDX_W = (BUF_NUM > 1) ? $clog2(BUF_NUM) : 1
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             cmos_vsync,
    output logic             write_req,
    input  logic             write_req_ack,
    input  logic             write_done,
    output logic [IDX_W-1:0] write_addr_index,
    input  logic             read_frame_start,
    output logic [IDX_W-1:0] read_addr_index,
    output logic             frame_valid,
    output logic [15:0]      frame_drop_cnt
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_WRITING = 2'd2;

    logic             vs_d0_q, vs_d0_d;
    logic             vs_d1_q, vs_d1_d;
    logic [1:0]       state_q, state_d;
    logic             wreq_q, wreq_d;
    logic [IDX_W-1:0] wi_q, wi_d;
    logic [IDX_W-1:0] ri_q, ri_d;
    logic [IDX_W-1:0] latest_q, latest_d;
    logic             fv_q, fv_d;

    logic             vs_rise;
    logic             commit;
    logic             drop_inc;
    logic [IDX_W-1:0] inc1;
    logic [IDX_W-1:0] nxt;

    // (v + 1) mod BUF_NUM, computed one bit wider so BUF_NUM = 2**IDX_W wraps too
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] v);
        logic [IDX_W:0] s;
        s = {1'b0, v} + (IDX_W+1)'(1);
        if (s >= (IDX_W+1)'(BUF_NUM)) begin
            idx_inc = '0;
        end else begin
            idx_inc = s[IDX_W-1:0];
        end
    endfunction

    // Two-flop vsync synchroniser and rising-edge detect
    always_comb begin
        vs_d0_d = cmos_vsync;
        vs_d1_d = vs_d0_q;
        vs_rise = vs_d0_q & ~vs_d1_q;
    end

    // A frame is committed whenever the writer finishes while we are writing
    assign commit = (state_q == ST_WRITING) && write_done;

    // Reader lock: bypass a same-cycle commit, otherwise take the latest frame
    always_comb begin
        ri_d = ri_q;
        if (read_frame_start) begin
            if (commit) begin
                ri_d = wi_q;
            end else if (fv_q) begin
                ri_d = latest_q;
            end
        end
    end

    // Next write buffer: step forward, skipping the buffer the reader holds next cycle
    always_comb begin
        inc1 = idx_inc(wi_q);
        nxt  = (inc1 == ri_d) ? idx_inc(inc1) : inc1;
    end

    // Writer handshake FSM: next state, buffer selection, commit and drop events
    always_comb begin
        state_d  = state_q;
        wreq_d   = wreq_q;
        wi_d     = wi_q;
        latest_d = latest_q;
        fv_d     = fv_q;
        drop_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (vs_rise) begin
                    wi_d    = nxt;
                    wreq_d  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (write_req_ack) begin
                    wreq_d   = 1'b0;
                    state_d  = ST_WRITING;
                    drop_inc = vs_rise;
                end else if (vs_rise) begin
                    drop_inc = 1'b1;
                end
            end
            ST_WRITING: begin
                if (write_done) begin
                    latest_d = wi_q;
                    fv_d     = 1'b1;
                    state_d  = ST_IDLE;
                    if (vs_rise) begin
                        wi_d    = nxt;
                        wreq_d  = 1'b1;
                        state_d = ST_REQ;
                    end
                end else if (vs_rise) begin
                    drop_inc = 1'b1;
                    wi_d     = nxt;
                    wreq_d   = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wreq_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge pclk) begin
        if (rst) begin
            vs_d0_q  <= 1'b0;
            vs_d1_q  <= 1'b0;
            state_q  <= ST_IDLE;
            wreq_q   <= 1'b0;
            wi_q     <= '0;
            ri_q     <= '0;
            latest_q <= '0;
            fv_q     <= 1'b0;
        end else begin
            vs_d0_q  <= vs_d0_d;
            vs_d1_q  <= vs_d1_d;
            state_q  <= state_d;
            wreq_q   <= wreq_d;
            wi_q     <= wi_d;
            ri_q     <= ri_d;
            latest_q <= latest_d;
            fv_q     <= fv_d;
        end
    end

`ifdef FRAME_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of dropped and aborted frames
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Drop counter register
    always_ff @(posedge pclk) begin
        if (rst) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign frame_drop_cnt = drop_cnt_q;
`else
    logic unused_drop_inc;
    assign unused_drop_inc = drop_inc;
    assign frame_drop_cnt  = 16'd0;
`endif

    assign write_req        = wreq_q;
    assign write_addr_index = wi_q;
    assign read_addr_index  = ri_q;
    assign frame_valid      = fv_q;

endmodule

// File: tb/tb_cmos_frame_buf_ctrl.sv
// Directed table-driven bench for cmos_frame_buf_ctrl (BUF_NUM = 3).
module tb_cmos_frame_buf_ctrl;

    logic        pclk;
    logic        rst;
    logic        cmos_vsync;
    logic        write_req;
    logic        write_req_ack;
    logic        write_done;
    logic [1:0]  write_addr_index;
    logic        read_frame_start;
    logic [1:0]  read_addr_index;
    logic        frame_valid;
    logic [15:0] frame_drop_cnt;

    int total;
    int bad;

`ifdef FRAME_DROP_CNT_EN
    localparam int SAT_DROPS = 65537;
`else
    localparam int SAT_DROPS = 5;
`endif

    cmos_frame_buf_ctrl dut (
        .pclk             (pclk),
        .rst              (rst),
        .cmos_vsync       (cmos_vsync),
        .write_req        (write_req),
        .write_req_ack    (write_req_ack),
        .write_done       (write_done),
        .write_addr_index (write_addr_index),
        .read_frame_start (read_frame_start),
        .read_addr_index  (read_addr_index),
        .frame_valid      (frame_valid),
        .frame_drop_cnt   (frame_drop_cnt)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic       rst;
        logic       vs;
        logic       ack;
        logic       done;
        logic       rfs;
        logic       wreq;
        logic [1:0] wi;
        logic [1:0] ri;
        logic       fv;
        int         drops;
    } vec_t;

    vec_t vecs[$];

    // Expected counter value for a given number of drop events
    function automatic logic [15:0] exp_cnt(input int n);
`ifdef FRAME_DROP_CNT_EN
        return (n > 65535) ? 16'hFFFF : 16'(n);
`else
        return (n >= 0) ? 16'd0 : 16'd0;
`endif
    endfunction

    task automatic add(input int r, input int vs, input int ack, input int done, input int rfs,
                       input int wreq, input int wi, input int ri, input int fv, input int drops);
        vec_t v;
        v.rst   = 1'(r);
        v.vs    = 1'(vs);
        v.ack   = 1'(ack);
        v.done  = 1'(done);
        v.rfs   = 1'(rfs);
        v.wreq  = 1'(wreq);
        v.wi    = 2'(wi);
        v.ri    = 2'(ri);
        v.fv    = 1'(fv);
        v.drops = drops;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int lat;
        bit seen;
        total            = 0;
        bad              = 0;
        rst              = 1'b1;
        cmos_vsync       = 1'b0;
        write_req_ack    = 1'b0;
        write_done       = 1'b0;
        read_frame_start = 1'b0;

        //  rst vs ack done rfs | wreq wi ri fv drops
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);  // reset
        add(0, 1, 0, 0, 0,  0, 0, 0, 0, 0);  // vsync sampled into d0
        add(0, 1, 0, 0, 0,  1, 1, 0, 0, 0);  // 2nd edge: request buffer 1
        add(0, 1, 1, 0, 0,  0, 1, 0, 0, 0);  // ack
        add(0, 0, 0, 1, 0,  0, 1, 0, 1, 0);  // done -> frame_valid
        add(0, 0, 0, 0, 1,  0, 1, 1, 1, 0);  // reader locks latest=1
        add(0, 1, 0, 0, 0,  0, 1, 1, 1, 0);
        add(0, 1, 0, 0, 0,  1, 2, 1, 1, 0);  // next buffer 2
        add(0, 1, 1, 0, 0,  0, 2, 1, 1, 0);
        add(0, 0, 0, 1, 0,  0, 2, 1, 1, 0);
        add(0, 0, 0, 0, 1,  0, 2, 2, 1, 0);  // reader locks 2
        add(0, 1, 0, 0, 0,  0, 2, 2, 1, 0);
        add(0, 1, 0, 0, 0,  1, 0, 2, 1, 0);  // wraps to 0
        add(0, 1, 1, 0, 0,  0, 0, 2, 1, 0);
        add(0, 0, 0, 1, 0,  0, 0, 2, 1, 0);
        add(0, 0, 0, 0, 0,  0, 0, 2, 1, 0);
        add(0, 1, 0, 0, 0,  0, 0, 2, 1, 0);
        add(0, 1, 0, 0, 0,  1, 1, 2, 1, 0);  // wi=1, reader holds 2
        add(0, 1, 1, 0, 0,  0, 1, 2, 1, 0);
        add(0, 0, 0, 1, 0,  0, 1, 2, 1, 0);
        add(0, 0, 0, 0, 0,  0, 1, 2, 1, 0);
        add(0, 1, 0, 0, 0,  0, 1, 2, 1, 0);
        add(0, 1, 0, 0, 0,  1, 0, 2, 1, 0);  // skips 2 -> 0
        add(0, 0, 0, 0, 0,  1, 0, 2, 1, 0);
        add(0, 1, 0, 0, 0,  1, 0, 2, 1, 0);
        add(0, 1, 0, 0, 0,  1, 0, 2, 1, 1);  // rise without ack: drop, held
        add(0, 0, 0, 0, 0,  1, 0, 2, 1, 1);
        add(0, 1, 0, 0, 0,  1, 0, 2, 1, 1);
        add(0, 1, 1, 0, 0,  0, 0, 2, 1, 2);  // rise with ack: ack path + drop
        add(0, 0, 0, 0, 0,  0, 0, 2, 1, 2);
        add(0, 1, 0, 0, 0,  0, 0, 2, 1, 2);
        add(0, 1, 0, 0, 1,  1, 2, 1, 1, 3);  // abort; same-cycle reader lock 1 is skipped
        add(0, 1, 1, 0, 0,  0, 2, 1, 1, 3);
        add(0, 0, 0, 0, 0,  0, 2, 1, 1, 3);
        add(0, 1, 0, 0, 0,  0, 2, 1, 1, 3);
        add(0, 1, 0, 1, 0,  1, 0, 1, 1, 3);  // done+rise: commit then select, no drop
        add(0, 1, 1, 0, 0,  0, 0, 1, 1, 3);
        add(0, 0, 0, 1, 0,  0, 0, 1, 1, 3);
        add(0, 1, 0, 0, 1,  0, 0, 0, 1, 3);  // reader locks 0
        add(0, 1, 0, 0, 0,  1, 1, 0, 1, 3);
        add(0, 1, 1, 0, 0,  0, 1, 0, 1, 3);
        add(0, 0, 0, 1, 1,  0, 1, 1, 1, 3);  // done + read start: bypass to 1
        add(0, 0, 0, 0, 0,  0, 1, 1, 1, 3);
        add(0, 1, 0, 0, 0,  0, 1, 1, 1, 3);
        add(0, 1, 0, 0, 0,  1, 2, 1, 1, 3);  // avoids 1
        add(0, 1, 0, 1, 0,  1, 2, 1, 1, 3);  // done ignored in REQ
        add(0, 1, 1, 0, 0,  0, 2, 1, 1, 3);
        add(0, 1, 1, 0, 0,  0, 2, 1, 1, 3);  // ack ignored in WRITING
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);  // reset mid-frame
        add(0, 0, 0, 1, 0,  0, 0, 0, 0, 0);  // done ignored after reset
        add(0, 0, 0, 0, 1,  0, 0, 0, 0, 0);  // read start without valid frame

        foreach (vecs[i]) begin
            @(negedge pclk);
            rst              = vecs[i].rst;
            cmos_vsync       = vecs[i].vs;
            write_req_ack    = vecs[i].ack;
            write_done       = vecs[i].done;
            read_frame_start = vecs[i].rfs;
            @(posedge pclk);
            #1;
            chk($sformatf("v%0d write_req", i), 16'(write_req), 16'(vecs[i].wreq));
            chk($sformatf("v%0d write_addr_index", i), 16'(write_addr_index), 16'(vecs[i].wi));
            chk($sformatf("v%0d read_addr_index", i), 16'(read_addr_index), 16'(vecs[i].ri));
            chk($sformatf("v%0d frame_valid", i), 16'(frame_valid), 16'(vecs[i].fv));
            chk($sformatf("v%0d frame_drop_cnt", i), frame_drop_cnt, exp_cnt(vecs[i].drops));
        end

        // Request latency from a fresh vsync edge, bounded wait
        @(negedge pclk);
        rst              = 1'b0;
        write_req_ack    = 1'b0;
        write_done       = 1'b0;
        read_frame_start = 1'b0;
        cmos_vsync       = 1'b1;
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            @(posedge pclk);
            #1;
            if (write_req) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        chk("req_latency_edges", 16'(lat), 16'd2);
        chk("req_latency_wi", 16'(write_addr_index), 16'd1);

        // Repeated vsync while waiting for ack: every rise is a drop
        for (int n = 0; n < SAT_DROPS; n++) begin
            @(negedge pclk);
            cmos_vsync = 1'b0;
            @(negedge pclk);
            cmos_vsync = 1'b1;
        end
        @(posedge pclk);
        #1;
        chk("sat_drop_cnt", frame_drop_cnt, exp_cnt(SAT_DROPS));
        chk("sat_write_req", 16'(write_req), 16'd1);
        chk("sat_wi", 16'(write_addr_index), 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmos_frame_buf_ctrl.md
CMOS_FRAME_BUF_CTRL -- requirements
Module: cmos_frame_buf_ctrl

Interface
REQ-001 SHALL have parameter BUF_NUM, default 3, number of frame buffers (legal range 3..16).
REQ-002 SHALL have localparam IDX_W = max(1, clog2(BUF_NUM)), the width of the buffer index.
REQ-003 SHALL have port pclk, in, 1: sole clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, in, 1: reset, synchronous and active-high.
REQ-005 SHALL have port cmos_vsync, in, 1: raw sensor vsync; asynchronous to pclk.
REQ-006 SHALL have port write_req, out, 1: request to the frame writer to start a frame.
REQ-007 SHALL have port write_req_ack, in, 1: single-cycle pulse; the writer has accepted write_req.
REQ-008 SHALL have port write_done, in, 1: single-cycle pulse; the writer has finished the current frame.
REQ-009 SHALL have port write_addr_index, out, IDX_W: buffer currently being written.
REQ-010 SHALL have port read_frame_start, in, 1: single-cycle pulse; the display side begins a frame.
REQ-011 SHALL have port read_addr_index, out, IDX_W: buffer locked by the reader.
REQ-012 SHALL have port frame_valid, out, 1: at least one frame has been committed since reset.
REQ-013 SHALL have port frame_drop_cnt, out, 16: count of dropped or aborted frames.

Function
REQ-014 SHALL synchronise cmos_vsync through two flops (d0, d1); vs_rise = d0 & ~d1.
REQ-015 SHALL assert write_req on the 2nd pclk edge after cmos_vsync is first sampled high.
REQ-016 SHALL implement the FSM states IDLE, REQ and WRITING.
REQ-017 SHALL, in IDLE on vs_rise: write_addr_index <= nxt, write_req <= 1, go to REQ.
REQ-018 SHALL define nxt = (wi+1) mod BUF_NUM, or (wi+2) mod BUF_NUM if (wi+1) mod BUF_NUM equals rd_next.
REQ-019 SHALL define rd_next as the read_addr_index value being registered in the same cycle (so a same-cycle reader update is honoured).
REQ-020 SHALL, in REQ on write_req_ack: write_req <= 0, go to WRITING.
REQ-021 SHALL, in REQ on vs_rise without ack: count one drop, keep write_req high, keep write_addr_index, stay in REQ.
REQ-022 SHALL, in REQ when vs_rise and ack occur together: take the ack path and also count one drop.
REQ-023 SHALL, in WRITING on write_done: latest_idx <= write_addr_index, frame_valid <= 1, go to IDLE.
REQ-024 SHALL, in WRITING on vs_rise without write_done: abort the frame with no commit, count one drop, select nxt, write_req <= 1, go to REQ.
REQ-025 SHALL, in WRITING when write_done and vs_rise occur together: commit first, then select nxt, write_req <= 1, go to REQ; no drop is counted.
REQ-026 SHALL, on read_frame_start with frame_valid = 1: read_addr_index <= latest_idx.
REQ-027 SHALL, on read_frame_start with frame_valid = 0: leave read_addr_index unchanged.
REQ-028 SHALL, when read_frame_start and a commit occur in the same cycle: bypass, read_addr_index <= the just-committed index.
REQ-029 SHALL ignore write_req_ack outside REQ and write_done outside WRITING.
REQ-030 SHALL never let write_addr_index equal read_addr_index after any selection.

Reset
REQ-031 SHALL, on rst = 1 at a pclk edge, clear d0, d1, write_req, write_addr_index, read_addr_index, latest_idx, frame_valid and frame_drop_cnt to 0 and set the FSM to IDLE.
REQ-032 SHALL give rst priority over all inputs, so mid-frame reset abandons the frame without counting a drop.

Configuration
REQ-033 SHALL, with macro FRAME_DROP_CNT_EN defined, make frame_drop_cnt a 16-bit counter that saturates at 0xFFFF.
REQ-034 SHALL, without FRAME_DROP_CNT_EN, tie frame_drop_cnt to 0 and contain no counter logic; all other behaviour is identical.

Verification
REQ-035 SHALL cover: reset, then vsync rise -> write_req high 2 edges later, write_addr_index=1; ack -> write_req=0; write_done -> frame_valid=1.
REQ-036 SHALL cover: BUF_NUM=3, read_addr_index=2, wi=1, vsync rise -> write_addr_index=0 (skips 2).
REQ-037 SHALL cover: two vsync rises with no ack -> write_addr_index unchanged, write_req held high, frame_drop_cnt=1.
REQ-038 SHALL cover: read_frame_start in the same cycle as write_done with wi=1 -> read_addr_index=1; next selection skips 1.
REQ-039 SHALL cover: with FRAME_DROP_CNT_EN, 65537 drops -> frame_drop_cnt=0xFFFF; without the macro -> 0.
REQ-040 SHALL cover: rst pulsed while in WRITING -> all outputs 0, FSM in IDLE, following write_done ignored.
